// File: rtl/cpu_peripheral_slave_agent.sv
// Avalon-MM pipelined slave: byte-writable register bank with wait states,
// fixed-latency reads, an in-flight read limit and register 0 exported as a PIO port.
module cpu_peripheral_slave_agent #(
    parameter int NUM_REGS     = 32,
    parameter int WAIT_STATES  = 1,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        endofpacket,
    output logic [31:0] pio_out
);

    localparam int         IDX_W      = $clog2(NUM_REGS);
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
    localparam logic [7:0] LAST_WORD  = 8'(NUM_REGS - 1);
    localparam logic [3:0] WS_LIMIT   = 4'(WAIT_STATES);
    localparam logic [3:0] PEND_MAX   = 4'(MAX_PENDING);

    logic             cmd;
    logic             rd_only;
    logic             ws_busy;
    logic             pend_full;
    logic             accept;
    logic             wr_acc;
    logic             rd_acc;
    logic [3:0]       ws_cnt;
    logic [3:0]       pend;
    logic [7:0]       word;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      regs [NUM_REGS];
    logic [31:0]      rd_word;
    logic             rd_eop;
    logic             last_vld;
    logic [31:0]      last_data;
    logic             last_eop;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^address[1:0];

    // Command decode: a simultaneous read+write is handled as a write only.
    assign cmd      = read | write;
    assign rd_only  = read & ~write;
    assign word     = {1'b0, address[8:2]};
    assign in_range = (word < NUM_REGS_W);
    assign idx      = address[IDX_W+1:2];

    // ws_cnt never exceeds WS_LIMIT, so equality marks the end of the wait states.
    assign ws_busy     = (ws_cnt != WS_LIMIT);
    assign pend_full   = (pend == PEND_MAX);
    assign waitrequest = reset | (cmd & (ws_busy | (rd_only & pend_full)));
    assign accept      = cmd & ~waitrequest;
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & rd_only;

    assign rd_word = in_range ? regs[idx] : 32'h0000_0000;
    assign rd_eop  = in_range & (word == LAST_WORD);
    assign pio_out = regs[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_cnt <= 4'd0;
        end else if (!cmd || accept) begin
            ws_cnt <= 4'd0;
        end else if (ws_busy) begin
            ws_cnt <= ws_cnt + 4'd1;
        end
    end

    // A retirement in the same cycle as a new accept leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 4'd0;
        end else begin
            case ({rd_acc, readdatavalid})
                2'b10:   pend <= pend + 4'd1;
                2'b01:   pend <= pend - 4'd1;
                default: pend <= pend;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (wr_acc && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    regs[idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Stage p0: read sampled in the accept cycle; READ_LATENCY-1 shift stages
    // feed the registered response outputs.
    if (READ_LATENCY == 1) begin : g_direct
        assign last_vld  = rd_acc;
        assign last_data = rd_word;
        assign last_eop  = rd_eop;
    end else begin : g_pipe
        localparam int D = READ_LATENCY - 1;

        logic        vld_p  [D];
        logic [31:0] data_p [D];
        logic        eop_p  [D];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < D; i++) begin
                    vld_p[i] <= 1'b0;
                end
            end else begin
                vld_p[0] <= rd_acc;
                for (int i = 1; i < D; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            data_p[0] <= rd_word;
            eop_p[0]  <= rd_eop;
            for (int i = 1; i < D; i++) begin
                data_p[i] <= data_p[i-1];
                eop_p[i]  <= eop_p[i-1];
            end
        end

        assign last_vld  = vld_p[D-1];
        assign last_data = data_p[D-1];
        assign last_eop  = eop_p[D-1];
    end

    // Output stage: readdata holds between responses, endofpacket only with a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdatavalid <= 1'b0;
            endofpacket   <= 1'b0;
            readdata      <= 32'h0000_0000;
        end else begin
            readdatavalid <= last_vld;
            endofpacket   <= last_vld & last_eop;
            if (last_vld) begin
                readdata <= last_data;
            end
        end
    end

endmodule

// File: doc/cpu_peripheral_slave_agent.md
# cpu_peripheral_slave_agent

Avalon-MM pipelined slave that terminates the peripheral-side master port of the CPU-to-peripheral clock-crossing bridge. It holds a bank of byte-writable 32-bit registers and answers reads with fixed, parameterised latency through `readdatavalid`. Configurable wait states and an in-flight read limit drive `waitrequest`, so the bridge's hold-on-wait and upstream flow control are exercised. Register 0 is also driven out as a parallel port for board LEDs and test hooks.

## Interface
- `NUM_REGS`, 32, register count; power of 2, 2..128.
- `WAIT_STATES`, 1, `waitrequest` cycles inserted before each command is accepted; 0..15.
- `READ_LATENCY`, 2, cycles from read acceptance to `readdatavalid`; 1..8.
- `MAX_PENDING`, 2, maximum reads in flight; 1..`READ_LATENCY`.

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `address`  in  9  byte address; word index is `address[8:2]`; `address[1:0]` ignored.
- `byteenable`  in  4  write byte lanes; ignored for reads.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `waitrequest`  out  1  command not accepted this cycle.
- `readdata`  out  32  read data, valid with `readdatavalid`.
- `readdatavalid`  out  1  one-cycle read response strobe.
- `endofpacket`  out  1  high with `readdatavalid` when the response is for word `NUM_REGS-1`.
- `pio_out`  out  32  live contents of register 0.

## Operation
- **Command:** `cmd = read | write`. If both are asserted, the cycle is treated as a write and the read is dropped (protocol violation; no response).
- **Wait-state counter `ws_cnt`** (4 bit):
  - Increments each cycle `cmd` is high and `waitrequest` is high.
  - Clears to 0 on acceptance, or on any cycle with `cmd` low.
- **`waitrequest`** (combinational) = `reset | (cmd & ((ws_cnt < WAIT_STATES) | (read & !write & pend_full)))`.
  - Low when `cmd` is low and reset is not asserted.
  - The master holds `address`, `read`, `write`, `writedata` and `byteenable` stable while `waitrequest` is high.
- **Acceptance:** a cycle with `cmd` high and `waitrequest` low.
- **Write accept:**
  - Word in range (`address[8:2]` < `NUM_REGS`): each lane with its `byteenable` bit set is updated at the clock edge. `byteenable` = 0 is legal and changes nothing.
  - Word out of range: the write is silently dropped.
- **Read accept:**
  - Register contents are sampled in the accept cycle and pushed into a `READ_LATENCY`-deep valid/data/eop shift pipeline.
  - Out-of-range word returns 0x00000000, with eop = 0.
  - A write accepted in cycle k is visible to a read accepted in cycle k+1 or later.
- **Pending count `pend`** (0..`MAX_PENDING`):
  - +1 on read accept; −1 on a `readdatavalid` cycle; unchanged when both happen in the same cycle.
  - `pend_full = (pend == MAX_PENDING)`. A retirement in the same cycle does not free the slot; the read is accepted one cycle later.
  - Writes are never blocked by `pend_full`.
- **Ordering:** responses return strictly in issue order; one response per accepted read.
- **`pio_out`:** continuously equals register 0, so it updates the cycle after a write to word 0.

## Timing
- **Reset** (synchronous, takes effect at the clock edge while `reset` = 1):
  - All registers, `pio_out`, `readdata`, `readdatavalid`, `endofpacket`, `ws_cnt` and `pend` are 0.
  - Pipeline valid bits are cleared, so reads in flight are discarded with no response.
  - `waitrequest` is 1 while `reset` is high.
- **Command latency:** with `cmd` held from cycle 0, acceptance happens in cycle `WAIT_STATES`. With `WAIT_STATES` = 0, acceptance is in the same cycle.
- **Read latency:** a read accepted in cycle k gives `readdatavalid` = 1 in cycle k+`READ_LATENCY` for exactly one cycle. `readdata` and `endofpacket` are registered.
- **Idle outputs:** `readdata` holds its last value and `endofpacket` = 0 whenever `readdatavalid` = 0.
- **Throughput:**
  - Writes: one per `WAIT_STATES`+1 cycles.
  - Reads: additionally limited to `MAX_PENDING` per `READ_LATENCY`+1 cycles.
- **Deassert mid-wait:** if `cmd` drops during wait states, `ws_cnt` clears and nothing is accepted.

## Test plan
- **Byte-lane write:** `WAIT_STATES`=0. Write 0x11223344 with BE=1111 to word 3, then write 0xAABBCCDD with BE=0011 to word 3 (address 0x00C), then read word 3 → `readdatavalid` in cycle accept+2 with `readdata` = 0x1122CCDD and `endofpacket` = 0.
- **Wait states:** `WAIT_STATES`=2, hold a write of 0x5A5A5A5A to word 0 → `waitrequest` = 1,1,0 over cycles 0..2; `pio_out` = 0x5A5A5A5A from cycle 3.
- **In-flight limit:** `MAX_PENDING`=1, `READ_LATENCY`=2, `WAIT_STATES`=0, back-to-back reads of words 1 and 2 → first accepted in cycle 0; `waitrequest` high in cycles 1–2; second accepted in cycle 3; responses in cycles 2 and 5, in order.
- **Last word and out of range:** read word 31 (address 0x07C) → `endofpacket` = 1 with `readdatavalid`. With `NUM_REGS`=32, read word 40 → `readdata` = 0, `endofpacket` = 0. A write to word 40 leaves all registers unchanged.
- **Reset mid-flight:** accept 2 reads, assert `reset` for 1 cycle before the responses are due → no `readdatavalid`; `pio_out` = 0; `pend` = 0; the next read is accepted normally.
- **Read + write both asserted:** with `read` and `write` both high on word 5 → write performed; no response is ever produced.
